// File: rtl/fifo_stream_reader_if.sv
// Valid/ready output stream of the FIFO read controller.
// The controller drives the master side; the consumer holds the slave side.
interface fifo_stream_reader_if #(
    parameter int DATA_WIDTH = 8
) ();
    logic                  m_valid;
    logic                  m_ready;
    logic [DATA_WIDTH-1:0] m_data;

    modport master (output m_valid, output m_data, input m_ready);
    modport slave  (input m_valid, input m_data, output m_ready);
endinterface

// File: rtl/fifo_stream_reader.sv
// Read-side controller for the synchronous pointer FIFO: issues reads, absorbs the
// one-cycle registered read latency and re-times words through a 2-entry buffer.
module fifo_stream_reader #(
    parameter int DATA_WIDTH = 8,
    parameter int CNT_WIDTH  = 16
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  en,
    input  logic                  fifo_empty,
    input  logic [DATA_WIDTH-1:0] fifo_rdata,
    output logic                  fifo_rd_en,
    fifo_stream_reader_if.master  m,
    output logic [CNT_WIDTH-1:0]  word_cnt,
    output logic                  busy
);
    logic [1:0][DATA_WIDTH-1:0] buf_q;
    logic                       head;
    logic                       tail;
    logic [1:0]                 occ;
    logic                       inflight;
    logic                       pop;
    logic [2:0]                 demand;

    assign m.m_valid = (occ != 2'd0);
    assign m.m_data  = buf_q[head];
    assign pop       = m.m_valid & m.m_ready;
    assign busy      = (occ != 2'd0) | inflight;

    // Slots that will be taken after this edge; reading on a pop keeps one word/cycle.
    assign demand     = {1'b0, occ} + {2'b00, inflight} - {2'b00, pop};
    assign fifo_rd_en = rst_n & en & ~fifo_empty & (demand < 3'd2);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            buf_q    <= '0;
            head     <= 1'b0;
            tail     <= 1'b0;
            occ      <= 2'd0;
            inflight <= 1'b0;
            word_cnt <= '0;
        end else begin
            inflight <= fifo_rd_en;
            if (inflight) begin
                buf_q[tail] <= fifo_rdata;
                tail        <= ~tail;
            end
            if (pop) begin
                head     <= ~head;
                word_cnt <= word_cnt + 1'b1;
            end
            case ({inflight, pop})
                2'b10:   occ <= occ + 2'd1;
                2'b01:   occ <= occ - 2'd1;
                default: occ <= occ;
            endcase
        end
    end
endmodule

// File: tb/tb_fifo_stream_reader.sv
// Randomised bench: a queue-based FIFO feeds two readers (16-bit and 4-bit counters);
// delivered words are compared to the pushed sequence.
module tb_fifo_stream_reader;
    localparam int DW = 8;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          en = 1'b0;
    logic          fifo_empty = 1'b1;
    logic [DW-1:0] fifo_rdata = '0;
    logic          m_ready = 1'b0;
    logic          rd0, rd1, busy0, busy1;
    logic [15:0]   cnt0;
    logic [3:0]    cnt1;

    fifo_stream_reader_if #(.DATA_WIDTH(DW)) s0 ();
    fifo_stream_reader_if #(.DATA_WIDTH(DW)) s1 ();
    assign s0.m_ready = m_ready;
    assign s1.m_ready = m_ready;

    fifo_stream_reader #(.DATA_WIDTH(DW), .CNT_WIDTH(16)) dut0 (
        .clk(clk), .rst_n(rst_n), .en(en), .fifo_empty(fifo_empty),
        .fifo_rdata(fifo_rdata), .fifo_rd_en(rd0), .m(s0), .word_cnt(cnt0), .busy(busy0));
    fifo_stream_reader #(.DATA_WIDTH(DW), .CNT_WIDTH(4)) dut1 (
        .clk(clk), .rst_n(rst_n), .en(en), .fifo_empty(fifo_empty),
        .fifo_rdata(fifo_rdata), .fifo_rd_en(rd1), .m(s1), .word_cnt(cnt1), .busy(busy1));

    always #5 clk = ~clk;

    logic [DW-1:0] fq[$];
    logic [DW-1:0] out_q[$];
    logic [DW-1:0] in_q[$];
    int            pop_cyc[$];
    int            cyc = 0;
    int            empty_viol = 0;
    int            hold_viol = 0;
    logic          prev_stall = 1'b0;
    logic [DW-1:0] prev_data = '0;
    int            chk_cnt = 0;
    int            pass_cnt = 0;

    // FIFO model (registered data and empty flag) plus output monitor.
    always @(posedge clk) begin
        cyc++;
        if (rst_n) begin
            if (rd0 && fifo_empty) empty_viol++;
            if (rd0 && fq.size() > 0) fifo_rdata <= fq.pop_front();
            if (prev_stall && (!s0.m_valid || s0.m_data !== prev_data)) hold_viol++;
            prev_stall = s0.m_valid && !m_ready;
            prev_data  = s0.m_data;
            if (s0.m_valid && m_ready) begin
                out_q.push_back(s0.m_data);
                pop_cyc.push_back(cyc);
            end
        end else begin
            prev_stall = 1'b0;
        end
        fifo_empty <= (fq.size() == 0);
    end

    task automatic push(input logic [DW-1:0] v);
        fq.push_back(v);
        in_q.push_back(v);
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst_n = 1'b0; en = 1'b0; m_ready = 1'b0;
        fq.delete(); out_q.delete(); in_q.delete(); pop_cyc.delete();
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic wait_out(input int n, input int budget, output bit ok);
        int k = 0;
        while (out_q.size() < n && k < budget) begin
            @(negedge clk);
            k++;
        end
        ok = (out_q.size() >= n);
    endtask

    task automatic test_reset();
        bit ok;
        @(negedge clk);
        rst_n = 1'b0; en = 1'b1; m_ready = 1'b1;
        push(8'h55); push(8'h66);
        repeat (2) @(negedge clk);
        #1;
        chk_cnt++; if (rd0 !== 1'b0 || rd1 !== 1'b0) $display("FAIL reset_rd_en: got %b%b want 00", rd0, rd1); else pass_cnt++;
        chk_cnt++; if (s0.m_valid !== 1'b0 || s1.m_valid !== 1'b0) $display("FAIL reset_m_valid: got %b want 0", s0.m_valid); else pass_cnt++;
        chk_cnt++; if (busy0 !== 1'b0 || busy1 !== 1'b0) $display("FAIL reset_busy: got %b want 0", busy0); else pass_cnt++;
        chk_cnt++; if (cnt0 !== 16'd0 || cnt1 !== 4'd0) $display("FAIL reset_word_cnt: got %0d/%0d want 0", cnt0, cnt1); else pass_cnt++;
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        chk_cnt++; if (rd0 !== 1'b1) $display("FAIL release_first_read: got %b want 1", rd0); else pass_cnt++;
        @(negedge clk); #1;
        chk_cnt++; if (s0.m_valid !== 1'b0) $display("FAIL latency_early_valid: got %b want 0", s0.m_valid); else pass_cnt++;
        @(negedge clk); #1;
        chk_cnt++; if (s0.m_valid !== 1'b1 || s0.m_data !== 8'h55) $display("FAIL latency_first_word: got v=%b d=%h want v=1 d=55", s0.m_valid, s0.m_data); else pass_cnt++;
        wait_out(2, 20, ok);
        repeat (2) @(negedge clk);
        chk_cnt++; if (!ok || out_q[0] !== 8'h55 || out_q[1] !== 8'h66 || cnt0 !== 16'd2) $display("FAIL reset_drain: got n=%0d cnt=%0d want n=2 cnt=2", out_q.size(), cnt0); else pass_cnt++;
    endtask

    task automatic test_stream();
        bit ok;
        int errs = 0;
        do_reset();
        for (int i = 1; i <= 16; i++) push(DW'(i));
        @(negedge clk);
        en = 1'b1; m_ready = 1'b1;
        wait_out(16, 100, ok);
        for (int i = 0; i < 16 && i < out_q.size(); i++) if (out_q[i] !== in_q[i]) errs++;
        chk_cnt++; if (!ok || errs != 0) $display("FAIL stream_order: got n=%0d errs=%0d want n=16 errs=0", out_q.size(), errs); else pass_cnt++;
        chk_cnt++; if (!ok || pop_cyc[15] - pop_cyc[0] != 15) $display("FAIL stream_throughput: got span=%0d want 15", ok ? pop_cyc[15] - pop_cyc[0] : -1); else pass_cnt++;
        repeat (3) @(negedge clk); #1;
        chk_cnt++; if (cnt0 !== 16'd16 || s0.m_valid !== 1'b0 || busy0 !== 1'b0) $display("FAIL stream_end: got cnt=%0d v=%b busy=%b want 16 0 0", cnt0, s0.m_valid, busy0); else pass_cnt++;
    endtask

    task automatic test_backpressure();
        bit ok;
        int errs = 0;
        int hv = hold_viol;
        do_reset();
        for (int i = 0; i < 8; i++) push(8'hA0 + DW'(i));
        @(negedge clk);
        en = 1'b1; m_ready = 1'b0;
        repeat (10) @(negedge clk);
        #1;
        chk_cnt++; if (rd0 !== 1'b0 || busy0 !== 1'b1) $display("FAIL bp_full_no_read: got rd=%b busy=%b want 0 1", rd0, busy0); else pass_cnt++;
        chk_cnt++; if (s0.m_valid !== 1'b1 || s0.m_data !== 8'hA0) $display("FAIL bp_head: got v=%b d=%h want 1 a0", s0.m_valid, s0.m_data); else pass_cnt++;
        chk_cnt++; if (fq.size() != 6) $display("FAIL bp_fifo_untouched: got %0d left want 6", fq.size()); else pass_cnt++;
        m_ready = 1'b1;
        wait_out(8, 50, ok);
        for (int i = 0; i < 8 && i < out_q.size(); i++) if (out_q[i] !== in_q[i]) errs++;
        repeat (3) @(negedge clk);
        chk_cnt++; if (!ok || errs != 0 || out_q.size() != 8) $display("FAIL bp_order: got n=%0d errs=%0d want n=8 errs=0", out_q.size(), errs); else pass_cnt++;
        chk_cnt++; if (hold_viol != hv) $display("FAIL bp_stable: got %0d violations want 0", hold_viol - hv); else pass_cnt++;
    endtask

    task automatic test_random();
        int errs = 0;
        int pushed = 0;
        int k = 0;
        int ev = empty_viol;
        int hv = hold_viol;
        do_reset();
        en = 1'b1;
        while (out_q.size() < 200 && k < 4000) begin
            @(negedge clk);
            m_ready = 1'($urandom % 2);
            if (pushed < 200 && ($urandom % 2) == 0) begin
                push(DW'($urandom));
                pushed++;
            end
            k++;
        end
        m_ready = 1'b1;
        repeat (3) @(negedge clk);
        for (int i = 0; i < 200 && i < out_q.size(); i++) if (out_q[i] !== in_q[i]) errs++;
        chk_cnt++; if (out_q.size() != 200 || errs != 0) $display("FAIL rand_order: got n=%0d errs=%0d want n=200 errs=0", out_q.size(), errs); else pass_cnt++;
        chk_cnt++; if (cnt0 !== 16'd200 || cnt1 !== 4'd8) $display("FAIL rand_word_cnt: got %0d/%0d want 200/8", cnt0, cnt1); else pass_cnt++;
        chk_cnt++; if (empty_viol != ev) $display("FAIL rand_read_when_empty: got %0d want 0", empty_viol - ev); else pass_cnt++;
        chk_cnt++; if (hold_viol != hv) $display("FAIL rand_stall_stable: got %0d violations want 0", hold_viol - hv); else pass_cnt++;
    endtask

    task automatic test_en_toggle();
        bit ok;
        int errs = 0;
        int bad = 0;
        int gaps = 0;
        do_reset();
        for (int i = 0; i < 24; i++) push(8'h30 + DW'(i));
        @(negedge clk);
        en = 1'b1; m_ready = 1'b1;
        repeat (6) @(negedge clk);
        en = 1'b0;
        for (int i = 0; i < 5; i++) begin
            #1;
            if (rd0 !== 1'b0) bad++;
            @(negedge clk);
        end
        en = 1'b1;
        wait_out(24, 100, ok);
        repeat (3) @(negedge clk);
        for (int i = 0; i < 24 && i < out_q.size(); i++) if (out_q[i] !== in_q[i]) errs++;
        for (int i = 1; i < pop_cyc.size(); i++) if (pop_cyc[i] - pop_cyc[i-1] > 1) gaps++;
        chk_cnt++; if (bad != 0) $display("FAIL en_low_no_read: got %0d reads want 0", bad); else pass_cnt++;
        chk_cnt++; if (!ok || errs != 0 || out_q.size() != 24) $display("FAIL en_toggle_order: got n=%0d errs=%0d want n=24 errs=0", out_q.size(), errs); else pass_cnt++;
        chk_cnt++; if (gaps != 1) $display("FAIL en_toggle_single_pause: got %0d pauses want 1", gaps); else pass_cnt++;
    endtask

    task automatic test_wrap();
        bit ok;
        do_reset();
        for (int i = 0; i < 17; i++) push(DW'($urandom));
        @(negedge clk);
        en = 1'b1; m_ready = 1'b1;
        wait_out(17, 100, ok);
        repeat (3) @(negedge clk); #1;
        chk_cnt++; if (!ok || cnt1 !== 4'd1 || cnt0 !== 16'd17) $display("FAIL cnt_wrap: got %0d/%0d want 1/17", cnt1, cnt0); else pass_cnt++;
    endtask

    task automatic test_reset_mid();
        @(negedge clk);
        m_ready = 1'b0;
        for (int i = 0; i < 4; i++) push(8'hC0 + DW'(i));
        repeat (6) @(negedge clk);
        #1;
        chk_cnt++; if (s0.m_valid !== 1'b1 || rd0 !== 1'b0 || fq.size() != 2) $display("FAIL mid_full_pre: got v=%b rd=%b left=%0d want 1 0 2", s0.m_valid, rd0, fq.size()); else pass_cnt++;
        rst_n = 1'b0;
        #1;
        chk_cnt++; if (s0.m_valid !== 1'b0 || s1.m_valid !== 1'b0 || busy0 !== 1'b0 || rd0 !== 1'b0) $display("FAIL mid_reset_outputs: got v=%b busy=%b rd=%b want 0 0 0", s0.m_valid, busy0, rd0); else pass_cnt++;
        chk_cnt++; if (cnt0 !== 16'd0 || cnt1 !== 4'd0 || s0.m_data !== 8'h00) $display("FAIL mid_reset_cnt: got %0d/%0d d=%h want 0/0 00", cnt0, cnt1, s0.m_data); else pass_cnt++;
        @(negedge clk);
        fq.delete();
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    initial begin
        test_reset();
        test_stream();
        test_backpressure();
        test_random();
        test_en_toggle();
        test_wrap();
        test_reset_mid();
        $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
        $finish;
    end
endmodule
